mult_acc_param: RTL

Parametrised multiply / multiply-accumulate for the convolution PE array. It replaces the fixed 8x8 unsigned-pipelined multiplier with sign-extended output.
- Widths, multiplier pipeline depth and accumulation length are configurable.
- Signed or unsigned operands are selected per sample.
- Valid tracking is built in.
- An optional per-sample accumulate mode sums ACC_LEN products (for example a 3x3 kernel) before emitting one result with an overflow flag.
- Sits between line-buffer/weight fetch and the adder tree / requantiser.

---
 rtl/mult_acc_param_pkg.sv | 22 ++
 rtl/mult_pipe_sx.sv | 61 ++++++
 rtl/mult_acc_param.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mult_acc_param_pkg.sv
// Shared defaults, mode encodings and the per-sample sideband tag for the
// PE-array multiply / multiply-accumulate block.
package mult_acc_param_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_WEIGHT_W   = 8;
    localparam int unsigned DEF_OUT_W      = 20;
    localparam int unsigned DEF_MULT_LAT   = 2;
    localparam int unsigned KERNEL_ACC_LEN = 9;  // 3x3 kernel

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_ACC  = 1'b1;
    localparam logic UNSIGNED  = 1'b0;
    localparam logic SIGNED    = 1'b1;

    // Sideband that travels with each sample through the multiplier
    typedef struct packed {
        logic signed_mode;
        logic acc_en;
    } sample_tag_t;

endpackage

// File: rtl/mult_pipe_sx.sv
// MULT_LAT-stage signed/unsigned multiplier with a matching valid/tag delay line.
// The product is DATA_W+WEIGHT_W bits wide.
module mult_pipe_sx
    import mult_acc_param_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned MULT_LAT = DEF_MULT_LAT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [DATA_W-1:0]            a_i,
    input  logic [WEIGHT_W-1:0]          b_i,
    input  sample_tag_t                  tag_i,
    output logic                         valid_o,
    output logic [DATA_W+WEIGHT_W-1:0]   prod_o,
    output sample_tag_t                  tag_o
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    logic [PROD_W-1:0] prod_c;

    logic              valid_q [MULT_LAT];
    logic [PROD_W-1:0] prod_q  [MULT_LAT];
    sample_tag_t       tag_q   [MULT_LAT];

    // Extending both operands to PROD_W makes one modular multiply serve both modes
    always_comb begin
        a_x    = {{WEIGHT_W{tag_i.signed_mode & a_i[DATA_W-1]}}, a_i};
        b_x    = {{DATA_W{tag_i.signed_mode & b_i[WEIGHT_W-1]}}, b_i};
        prod_c = a_x * b_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                valid_q[i] <= 1'b0;
                prod_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            prod_q[0]  <= prod_c;
            tag_q[0]   <= tag_i;
            for (int unsigned i = 1; i < MULT_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                prod_q[i]  <= prod_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[MULT_LAT-1];
    assign prod_o  = prod_q[MULT_LAT-1];
    assign tag_o   = tag_q[MULT_LAT-1];

endmodule

// File: rtl/mult_acc_param.sv
// Parametrised multiply / multiply-accumulate: pipelined multiplier followed by
// one output stage that either passes the product or sums ACC_LEN products.
module mult_acc_param
    import mult_acc_param_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned OUT_W    = DEF_OUT_W,
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned ACC_LEN  = KERNEL_ACC_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [WEIGHT_W-1:0] weight_in,
    input  logic                signed_mode,
    input  logic                acc_en,
    output logic [OUT_W-1:0]    result_out,
    output logic                valid_out,
    output logic                ovf_out
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
    localparam int unsigned CNT_W  = $clog2(ACC_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    if (OUT_W < PROD_W || MULT_LAT < 1 || ACC_LEN < 1) begin : g_param_check
        $error("mult_acc_param: invalid parameter combination");
    end

    sample_tag_t       in_tag;
    sample_tag_t       m_tag;
    logic              m_valid;
    logic [PROD_W-1:0] m_prod;

    logic [OUT_W-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              sticky_q, sticky_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              valid_q,  valid_d;
    logic              ovf_q,    ovf_d;

    logic [OUT_W-1:0]  p_ext;
    logic [OUT_W:0]    sum_wide;
    logic              ovf_step;

    assign in_tag = '{signed_mode: signed_mode, acc_en: acc_en};

    mult_pipe_sx #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_in),
        .a_i     (data_in),
        .b_i     (weight_in),
        .tag_i   (in_tag),
        .valid_o (m_valid),
        .prod_o  (m_prod),
        .tag_o   (m_tag)
    );

    // Extend product to OUT_W and form the wrap-around sum with its carry
    always_comb begin
        p_ext    = (m_tag.signed_mode == SIGNED) ? OUT_W'($signed(m_prod)) : OUT_W'(m_prod);
        sum_wide = {1'b0, acc_q} + {1'b0, p_ext};
        if (m_tag.signed_mode == SIGNED) begin
            ovf_step = (acc_q[OUT_W-1] == p_ext[OUT_W-1]) &&
                       (sum_wide[OUT_W-1] != acc_q[OUT_W-1]);
        end else begin
            ovf_step = sum_wide[OUT_W];
        end
    end

    // Output stage: pass, or accumulate and emit on the last product of a frame
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        if (m_valid) begin
            if (m_tag.acc_en == MODE_PASS) begin
                cnt_d    = '0;
                result_d = p_ext;
                ovf_d    = 1'b0;
                valid_d  = 1'b1;
            end else begin
                if (cnt_q == '0) begin
                    acc_d    = p_ext;
                    sticky_d = 1'b0;
                end else begin
                    acc_d    = sum_wide[OUT_W-1:0];
                    sticky_d = sticky_q | ovf_step;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = acc_d;
                    ovf_d    = sticky_d;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_out = result_q;
    assign valid_out  = valid_q;
    assign ovf_out    = ovf_q;

endmodule
